risc_datapath: RTL and testbench
================================

Name: risc_datapath

Overview:
Execution end of the control-strobe interface driven by the VeriRISC controller. It holds the phase counter, PC, IR, accumulator, ALU, address mux and 32x8 program/data memory. It acts on the nine strobes each clock and returns `phase`, `opcode` and `zero` to the controller. The controller itself is purely combinational, so every state change in the CPU happens here.

Parameters:
- DWIDTH, 8, data/accumulator/IR width
- AWIDTH, 5, address width; memory depth is 2**AWIDTH
- OPW, 3, opcode width; opcode = ir[DWIDTH-1 -: OPW], operand = ir[AWIDTH-1:0]

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sel  in  1  1: mem_addr=pc, 0: mem_addr=IR operand
- rd  in  1  memory drives data bus
- ld_ir  in  1  load IR from data bus
- inc_pc  in  1  PC+1
- halt  in  1  stop machine
- ld_pc  in  1  PC <= IR operand
- data_e  in  1  accumulator drives data bus
- ld_ac  in  1  accumulator <= ALU result
- wr  in  1  memory[mem_addr] <= data bus
- prog_we  in  1  preload write strobe, honoured only while rst=1
- prog_addr  in  AWIDTH  preload address
- prog_data  in  DWIDTH  preload data
- phase  out  3  phase counter to controller
- opcode  out  OPW  IR opcode field to controller
- zero  out  1  accumulator == 0 (combinational)
- halted  out  1  sticky halt flag
- pc_addr  out  AWIDTH  program counter
- ac_value  out  DWIDTH  accumulator
- mem_addr  out  AWIDTH  current memory address (combinational)
- data_bus  out  DWIDTH  current bus value (combinational)
- bus_conflict  out  1  rd and data_e both high this cycle (combinational)

Behaviour:
- Reset (rst=1 at the edge): phase=0, pc=0, ir=0, ac=0, halted=0. Consequently opcode=0, zero=1, mem_addr=0 when sel=1. Memory is not cleared; prog_we writes mem[prog_addr]. All strobes are ignored during reset.
- Phase: +1 per clock, wraps 7->0. It freezes while halted=1 or halt=1.
- halted: set on the edge where halt=1. Cleared only by rst. While halted, no registers or memory change, whatever the strobes.
- mem_addr = sel ? pc : ir[AWIDTH-1:0].
- data_bus = rd ? mem[mem_addr] : (data_e ? ac : 0). rd has priority; bus_conflict=1 when both are high.
- Memory: asynchronous read, synchronous write. When wr=1, mem[mem_addr] <= data_bus at the edge. Reads in the same cycle return the old value.
- IR: ld_ir -> ir <= data_bus. Repeated loads in phases 2 and 3 are harmless.
- PC: ld_pc wins over inc_pc. inc_pc wraps 2**AWIDTH-1 -> 0.
- ALU result, selected by the current opcode:
  - ADD: (ac+bus) mod 2**DWIDTH, carry discarded
  - AND: ac&bus
  - XOR: ac^bus
  - LDA: bus
  - HLT, SKZ, STO, JMP: ac unchanged
- AC: ld_ac -> ac <= ALU result.
- Simultaneous strobes are applied independently on the same edge, using pre-edge values. Example: ld_ir with ld_ac uses the old opcode.
- Latency: every register update is visible the cycle after its strobe. zero, mem_addr, data_bus and bus_conflict are combinational from current state and strobes.

Decomposition:
- Package risc_pkg holds:
  - opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
  - default DWIDTH/AWIDTH
  - phase type
- One sub-module, risc_mem: AWIDTH x DWIDTH, async read, sync write, preload port muxed in during rst.
- The ALU is an inline case statement, not a separate module.

Test Plan:
1. Reset with prog_we preloading mem[0]=8'hA3 -> phase=0, pc_addr=0, ac_value=0, zero=1, halted=0. Then 9 idle clocks -> phase 1..7,0,1 and pc_addr stays 0.
2. Fetch: sel=rd=ld_ir=1 for one clock -> opcode=5 (LDA). Then sel=0 -> mem_addr=3. Then inc_pc -> pc_addr=1.
3. ALU with ac=8'h0F and mem[3]=8'hF1, rd+ld_ac under each opcode:
   - ADD -> ac=8'h00, zero=1
   - AND -> 8'h01
   - XOR -> 8'hFE
   - LDA -> 8'hF1
   - JMP -> ac unchanged
4. PC: pc=31 with inc_pc -> 0. Operand 3 with ld_pc=inc_pc=1 -> pc=3.
5. Store and conflict:
   - ac=8'h5A, operand 7, data_e=wr=1 -> mem[7]=8'h5A on the next read.
   - rd=data_e=1 -> data_bus=mem value, bus_conflict=1.
6. Halt: halt=1 at phase 4 -> halted=1. phase holds at 4 for 10 clocks while inc_pc/ld_ac/wr strobes change nothing. Then rst -> phase=0, halted=0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the VeriRISC datapath.
//   - default data/address/opcode widths
//   - opcode encoding seen by the controller and the inline ALU
//   - phase counter type
package risc_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 5;
    localparam int OPW_DEF    = 3;

    typedef logic [2:0] phase_t;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

endpackage

// File: rtl/risc_mem.sv
// risc_mem: 2**AWIDTH x DWIDTH program/data memory.
//   Asynchronous read, synchronous write. While rst is high the preload
//   port owns the write side so a program can be loaded during reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   prog_we/addr/data        preload write, honoured only while rst=1
//   wr, addr, wdata          run-time write (caller gates with halt)
//   rdata                    mem[addr], combinational
module risc_mem
    import risc_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data,
    input  logic              wr,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wval;

    // Run-time strobes are ignored during reset; only the preload port writes.
    assign we    = rst ? prog_we   : wr;
    assign waddr = rst ? prog_addr : addr;
    assign wval  = rst ? prog_data : wdata;

    // Contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wval;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/risc_datapath.sv
// risc_datapath: execution side of the VeriRISC CPU. Holds the phase
// counter, PC, IR, accumulator, ALU, address mux and memory, and acts on
// the controller's strobes every clock.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   sel rd ld_ir inc_pc halt      controller strobes
//   ld_pc data_e ld_ac wr
//   prog_we/addr/data             memory preload during reset
//   phase opcode zero             status back to the controller
//   halted pc_addr ac_value       visible machine state
//   mem_addr data_bus             combinational address and bus
//   bus_conflict                  rd and data_e both asserted
module risc_datapath
    import risc_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int OPW    = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic              prog_we,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data,
    output logic [2:0]        phase,
    output logic [OPW-1:0]    opcode,
    output logic              zero,
    output logic              halted,
    output logic [AWIDTH-1:0] pc_addr,
    output logic [DWIDTH-1:0] ac_value,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] data_bus,
    output logic              bus_conflict
);

    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] ac;
    logic [DWIDTH-1:0] mem_rdata;
    logic [DWIDTH-1:0] alu_result;

    assign opcode       = ir[DWIDTH-1 -: OPW];
    assign zero         = (ac == '0);
    assign pc_addr      = pc;
    assign ac_value     = ac;
    assign mem_addr     = sel ? pc : ir[AWIDTH-1:0];
    // Memory wins the bus; the conflict flag lets the system catch a bad
    // controller instead of silently resolving it.
    assign data_bus     = rd ? mem_rdata : (data_e ? ac : '0);
    assign bus_conflict = rd & data_e;

    risc_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .wr        (wr & ~halted),
        .addr      (mem_addr),
        .wdata     (data_bus),
        .rdata     (mem_rdata)
    );

    // Opcodes that don't load the accumulator pass it through, so a stray
    // ld_ac under them is harmless.
    always_comb begin
        alu_result = ac;
        case (opcode)
            OPW'(ADD): alu_result = ac + data_bus;
            OPW'(AND): alu_result = ac & data_bus;
            OPW'(XOR): alu_result = ac ^ data_bus;
            OPW'(LDA): alu_result = data_bus;
            default:   alu_result = ac;
        endcase
    end

    // All strobes act on pre-edge values; once halted nothing moves until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= '0;
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (halt) halted <= 1'b1;
            else      phase  <= phase + 3'd1;
            if (ld_ir) ir <= data_bus;
            if (ld_pc)       pc <= ir[AWIDTH-1:0];
            else if (inc_pc) pc <= pc + AWIDTH'(1);
            if (ld_ac) ac <= alu_result;
        end
    end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: a behavioural machine model runs in
// parallel and is compared on every falling edge, plus literal checks at
// the key points of each scenario.
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       rst, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] phase;
    logic [2:0] opcode;
    logic       zero, halted, bus_conflict;
    logic [4:0] pc_addr, mem_addr;
    logic [7:0] ac_value, data_bus;

    int n_cmp = 0;
    int n_err = 0;

    risc_datapath dut (
        .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir),
        .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc), .data_e(data_e),
        .ld_ac(ld_ac), .wr(wr), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .phase(phase), .opcode(opcode), .zero(zero),
        .halted(halted), .pc_addr(pc_addr), .ac_value(ac_value),
        .mem_addr(mem_addr), .data_bus(data_bus), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase, m_pc, m_ir, m_ac;
    bit m_halted;
    bit model_ok = 0;
    int m_mem   [32];
    bit m_known [32];

    function automatic int exp_addr();
        return sel ? m_pc : (m_ir % 32);
    endfunction

    function automatic int exp_bus();
        if (rd)     return m_mem[exp_addr()];
        if (data_e) return m_ac;
        return 0;
    endfunction

    function automatic bit bus_known();
        return rd ? m_known[exp_addr()] : 1'b1;
    endfunction

    always @(posedge clk) begin
        int a, b, op, nac, npc;
        if (rst) begin
            m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;
            model_ok = 1;
            if (prog_we) begin
                m_mem[prog_addr]   = prog_data;
                m_known[prog_addr] = 1;
            end
        end else if (model_ok && !m_halted) begin
            a  = exp_addr();
            b  = exp_bus();
            op = m_ir / 32;
            nac = m_ac;
            case (op)
                2: nac = (m_ac + b) % 256;
                3: nac = m_ac & b;
                4: nac = m_ac ^ b;
                5: nac = b;
                default: nac = m_ac;
            endcase
            npc = m_pc;
            if (ld_pc)       npc = m_ir % 32;
            else if (inc_pc) npc = (m_pc + 1) % 32;
            if (wr) begin
                m_mem[a]   = b;
                m_known[a] = bus_known();
            end
            if (ld_ir) m_ir = b;
            if (ld_ac) m_ac = nac;
            m_pc = npc;
            if (halt) m_halted = 1;
            else      m_phase = (m_phase + 1) % 8;
        end
    end

    // Compare process: registers and combinational outputs every cycle.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_phase",    phase,        m_phase);
            chk("m_opcode",   opcode,       m_ir / 32);
            chk("m_zero",     zero,         (m_ac == 0));
            chk("m_halted",   halted,       m_halted);
            chk("m_pc",       pc_addr,      m_pc);
            chk("m_ac",       ac_value,     m_ac);
            chk("m_mem_addr", mem_addr,     exp_addr());
            chk("m_conflict", bus_conflict, (rd && data_e));
            if (bus_known()) chk("m_data_bus", data_bus, exp_bus());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic s, r, li, ip, h, lp, de, la, w);
        sel = s; rd = r; ld_ir = li; inc_pc = ip; halt = h;
        ld_pc = lp; data_e = de; ld_ac = la; wr = w;
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_begin();
        idle();
        prog_we = 0;
        rst = 1;
        step();
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        step();
    endtask

    task automatic rst_end();
        prog_we = 0;
        rst = 0;
    endtask

    logic [7:0] alu_instr [5] = '{8'h43, 8'h63, 8'h83, 8'hA3, 8'hE3};
    logic [7:0] alu_exp   [5] = '{8'h00, 8'h01, 8'hFE, 8'hF1, 8'h0F};

    initial begin
        rst = 1; prog_we = 0; prog_addr = '0; prog_data = '0;
        idle();

        // 1. reset + preload, then free-running phase
        rst_begin();
        preload(5'd0, 8'hA3);
        rst_end();
        chk("rst_phase",  phase,    0);
        chk("rst_pc",     pc_addr,  0);
        chk("rst_ac",     ac_value, 0);
        chk("rst_zero",   zero,     1);
        chk("rst_halted", halted,   0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("idle_phase", phase,   (i + 1) % 8);
            chk("idle_pc",    pc_addr, 0);
        end

        // 2. fetch
        set(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("fetch_opcode", opcode, 5);
        idle();
        #1 chk("operand_addr", mem_addr, 3);
        inc_pc = 1;
        step();
        chk("inc_pc", pc_addr, 1);
        idle();

        // 3. ALU: ac=0F, operand data F1, each opcode
        for (int k = 0; k < 5; k++) begin
            rst_begin();
            preload(5'd0, 8'hA4);
            preload(5'd1, alu_instr[k]);
            preload(5'd3, 8'hF1);
            preload(5'd4, 8'h0F);
            rst_end();
            set(1, 1, 1, 1, 0, 0, 0, 0, 0); step();
            set(0, 1, 0, 0, 0, 0, 0, 1, 0); step();
            chk("alu_seed", ac_value, 8'h0F);
            set(1, 1, 1, 1, 0, 0, 0, 0, 0); step();
            set(0, 1, 0, 0, 0, 0, 0, 1, 0); step();
            chk("alu_result", ac_value, alu_exp[k]);
            chk("alu_zero",   zero,     (alu_exp[k] == 8'h00));
            idle();
        end

        // 4. PC wrap and ld_pc priority
        rst_begin();
        preload(5'd0,  8'hFF);
        preload(5'd31, 8'hE3);
        rst_end();
        set(1, 1, 1, 0, 0, 0, 0, 0, 0); step();
        set(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        chk("ld_pc_31", pc_addr, 31);
        set(1, 1, 1, 1, 0, 0, 0, 0, 0); step();
        chk("pc_wrap", pc_addr, 0);
        chk("jmp_op",  opcode,  7);
        set(0, 0, 0, 1, 0, 1, 0, 0, 0); step();
        chk("ld_pc_wins", pc_addr, 3);
        idle();

        // 5. conflict and store
        rst_begin();
        preload(5'd0, 8'hA2);
        preload(5'd1, 8'hC7);
        preload(5'd2, 8'h5A);
        preload(5'd7, 8'h33);
        rst_end();
        set(1, 1, 1, 1, 0, 0, 0, 0, 0); step();
        set(0, 1, 0, 0, 0, 0, 0, 1, 0); step();
        chk("sto_ac", ac_value, 8'h5A);
        set(1, 1, 1, 1, 0, 0, 0, 0, 0); step();
        set(0, 1, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("conf_bus",  data_bus,     8'h33);
        chk("conf_flag", bus_conflict, 1);
        chk("conf_addr", mem_addr,     7);
        step();
        set(0, 0, 0, 0, 0, 0, 1, 0, 1);
        #1 chk("sto_bus", data_bus, 8'h5A);
        step();
        set(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("sto_read", data_bus, 8'h5A);
        step();
        idle();

        // 6. halt freezes everything
        rst_begin();
        preload(5'd0, 8'hA1);
        preload(5'd1, 8'h77);
        rst_end();
        set(1, 1, 1, 0, 0, 0, 0, 0, 0); step();
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("pre_halt_phase", phase, 4);
        halt = 1; step();
        halt = 0;
        chk("halt_set",   halted, 1);
        chk("halt_phase", phase,  4);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) set(1, 1, 1, 1, 0, 0, 0, 1, 0);
            else            set(0, 0, 0, 0, 0, 0, 1, 0, 1);
            step();
            chk("frz_phase", phase,    4);
            chk("frz_pc",    pc_addr,  0);
            chk("frz_ac",    ac_value, 0);
            chk("frz_halt",  halted,   1);
        end
        set(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("frz_mem", data_bus, 8'h77);
        idle();
        rst = 1; step();
        rst = 0;
        chk("unhalt_phase",  phase,  0);
        chk("unhalt_halted", halted, 0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
